shared_reg_arbiter: RTL

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - four-requester round-robin arbiter guarding one shared register
// Each write takes IDLE -> GRANT -> ACK; an aborted grant returns straight to IDLE.
module shared_reg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       last_id,
  output logic [7:0]       wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       winner_q, winner_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       last_id_q, last_id_d;
  logic [7:0]       wr_count_q, wr_count_d;

  logic             pick_valid;
  logic [1:0]       pick_id;
  logic [WIDTH-1:0] win_data;

  // Scan from the highest offset down so the offset closest to ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        pick_valid = 1'b1;
        pick_id    = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    win_data = d0;
    case (winner_q)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    gnt_d      = 4'b0000;
    ack_d      = 4'b0000;
    q_d        = q_q;
    last_id_d  = last_id_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          winner_d = pick_id;
          gnt_d    = 4'b0001 << pick_id;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (req[winner_q]) begin
          q_d        = win_data;
          last_id_d  = winner_q;
          wr_count_d = wr_count_q + 8'd1;
          ack_d      = 4'b0001 << winner_q;
          state_d    = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        ptr_d   = winner_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      winner_q   <= 2'd0;
      gnt_q      <= 4'b0000;
      ack_q      <= 4'b0000;
      q_q        <= '0;
      last_id_q  <= 2'd0;
      wr_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      q_q        <= q_d;
      last_id_q  <= last_id_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign busy     = (state_q != IDLE);
  assign q        = q_q;
  assign last_id  = last_id_q;
  assign wr_count = wr_count_q;

endmodule
